uart_rx_deframer: RTL

//  Serial receiver directly downstream of the UART transmit stage; consumes its tx line.

---
 rtl/uart_rx_deframer_pkg.sv | 22 ++
 rtl/uart_rx_deframer_if.sv | 25 ++
 rtl/uart_rx_deframer_sync.sv | 29 ++
 rtl/uart_rx_deframer.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/uart_rx_deframer_pkg.sv
// Shared types and constants for the UART receive deframer.
package uart_rx_deframer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int   UART_FRAME_BITS   = 11;
  localparam int   UART_CLKS_PER_BIT = 8;
  localparam logic START_BIT         = 1'b0;
  localparam logic STOP_BIT          = 1'b1;

  // Zero-extending a narrower payload into the argument leaves its parity unchanged.
  function automatic logic even_parity(input logic [31:0] value);
    return ^value;
  endfunction

endpackage

// File: rtl/uart_rx_deframer_if.sv
// Serial line plus the valid/rd read port of the receive buffer.
interface uart_rx_deframer_if #(
  parameter int DATA_BITS = 8
);

  logic                 rx;
  logic                 rd;
  logic [DATA_BITS-1:0] data_out;
  logic                 valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport slave (
    input  rx, rd,
    output data_out, valid, parity_err, frame_err, overrun, busy
  );

  modport master (
    output rx, rd,
    input  data_out, valid, parity_err, frame_err, overrun, busy
  );

endinterface

// File: rtl/uart_rx_deframer_sync.sv
// Metastability synchronizer for the serial line plus a falling-edge strobe.
module uart_rx_deframer_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rx_i,
  output logic rxs_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Flops preset high so a reset looks like an idle line, not a start bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rxs_o  = sync_q[SYNC_STAGES-1];
  assign fall_o = prev_q & ~rxs_o;

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receiver: recovers start/8-data/even-parity/stop frames into a one-entry read buffer.
module uart_rx_deframer
  import uart_rx_deframer_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int SYNC_STAGES  = 2
) (
  input logic                clk_i,
  input logic                rst_ni,
  uart_rx_deframer_if.slave  bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic rxs;
  logic fall;

  uart_rx_deframer_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .rx_i   (bus.rx),
    .rxs_o  (rxs),
    .fall_o (fall)
  );

  rx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bitCnt_q, bitCnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 stopSample_q, stopSample_d;
  logic                 commit_q, commit_d;
  logic                 valid_q, valid_d;
  logic                 parErr_q, parErr_d;
  logic                 frameErr_q, frameErr_d;
  logic                 overrun_q, overrun_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bitCnt_q     <= '0;
      shreg_q      <= '0;
      data_q       <= '0;
      perr_q       <= 1'b0;
      stopSample_q <= 1'b0;
      commit_q     <= 1'b0;
      valid_q      <= 1'b0;
      parErr_q     <= 1'b0;
      frameErr_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bitCnt_q     <= bitCnt_d;
      shreg_q      <= shreg_d;
      data_q       <= data_d;
      perr_q       <= perr_d;
      stopSample_q <= stopSample_d;
      commit_q     <= commit_d;
      valid_q      <= valid_d;
      parErr_q     <= parErr_d;
      frameErr_q   <= frameErr_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    bitCnt_d     = bitCnt_q;
    shreg_d      = shreg_q;
    perr_d       = perr_q;
    stopSample_d = stopSample_q;
    commit_d     = 1'b0;
    data_d       = data_q;
    valid_d      = valid_q;
    parErr_d     = parErr_q;
    frameErr_d   = frameErr_q;
    overrun_d    = overrun_q;

    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        bitCnt_d = '0;
        if (fall) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d   = '0;
          state_d = (rxs == START_BIT) ? DATA : IDLE;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          shreg_d  = {shreg_q[DATA_BITS-2:0], rxs};
          bitCnt_d = bitCnt_q + BW'(1);
          if (bitCnt_q == BIT_LAST) state_d = PARITY;
        end
      end
      PARITY: begin
        if (cnt_q == CNT_LAST) begin
          perr_d  = rxs ^ even_parity(32'(shreg_q));
          state_d = STOP;
        end
      end
      STOP: begin
        // The cycle after the stop sample commits; a start edge seen here is not lost.
        if (commit_q) begin
          cnt_d    = '0;
          bitCnt_d = '0;
          state_d  = fall ? START : IDLE;
        end else if (cnt_q == CNT_LAST) begin
          stopSample_d = rxs;
          commit_d     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A commit beats a simultaneous read: the new byte replaces the one being consumed.
    if (commit_q) begin
      data_d     = shreg_q;
      parErr_d   = perr_q;
      frameErr_d = (stopSample_q != STOP_BIT);
      valid_d    = 1'b1;
      overrun_d  = valid_q & ~bus.rd;
    end else if (bus.rd && valid_q) begin
      valid_d    = 1'b0;
      parErr_d   = 1'b0;
      frameErr_d = 1'b0;
      overrun_d  = 1'b0;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.valid      = valid_q;
  assign bus.parity_err = parErr_q;
  assign bus.frame_err  = frameErr_q;
  assign bus.overrun    = overrun_q;
  assign bus.busy       = (state_q != IDLE);

endmodule
